// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one combinational ALU through a single issue register.
// Define ALU_SHARE_ARBITER_FIXED_PRIO_EN to make requester 0 always win ties instead of round robin.
module alu_share_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [1:0]  req_v_i,
  input  logic [63:0] req_op_i,
  input  logic [63:0] req_rs1_i,
  input  logic [63:0] req_rs2_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  resp_v_o,
  output logic [63:0] resp_data_o,
  output logic [1:0]  resp_jump_o,
  input  logic [1:0]  resp_yumi_i,
  output logic [31:0] alu_op_o,
  output logic [31:0] alu_rs1_o,
  output logic [31:0] alu_rs2_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_jump_i
);
  typedef enum logic {IDLE, ISSUE} state_e;
  state_e state_q, state_d;
  logic [31:0] op_q, rs1_q, rs2_q;
  logic [31:0] data_q [2];
  logic [1:0] resp_v_q, jump_q, elig, wb;
  logic owner_q, gnt, acc;
`ifndef ALU_SHARE_ARBITER_FIXED_PRIO_EN
  logic last_q;
`endif
  // A requester may only issue if its response slot will have room when the op writes back.
  always_comb begin
    for (int r = 0; r < 2; r++)
      elig[r] = req_v_i[r] & (~resp_v_q[r] | resp_yumi_i[r]) & ~(state_q == ISSUE && owner_q == 1'(r));
`ifdef ALU_SHARE_ARBITER_FIXED_PRIO_EN
    gnt = ~elig[0];
`else
    gnt = &elig ? ~last_q : elig[1];
`endif
    acc = |elig & ~reset_i;
    req_ready_o = acc ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    state_d = acc ? ISSUE : IDLE;
    wb = state_q == ISSUE ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    alu_op_o = state_q == ISSUE ? op_q : '0;
    alu_rs1_o = state_q == ISSUE ? rs1_q : '0;
    alu_rs2_o = state_q == ISSUE ? rs2_q : '0;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      op_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      owner_q <= 1'b0;
      resp_v_q <= '0;
      jump_q <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
`ifndef ALU_SHARE_ARBITER_FIXED_PRIO_EN
      last_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (acc) begin
        op_q <= gnt ? req_op_i[63:32] : req_op_i[31:0];
        rs1_q <= gnt ? req_rs1_i[63:32] : req_rs1_i[31:0];
        rs2_q <= gnt ? req_rs2_i[63:32] : req_rs2_i[31:0];
        owner_q <= gnt;
`ifndef ALU_SHARE_ARBITER_FIXED_PRIO_EN
        last_q <= gnt;
`endif
      end
      resp_v_q <= wb | (resp_v_q & ~resp_yumi_i);
      for (int r = 0; r < 2; r++)
        if (wb[r]) begin
          data_q[r] <= alu_result_i;
          jump_q[r] <= alu_jump_i;
        end
    end
  end
  assign resp_v_o = resp_v_q;
  assign resp_jump_o = jump_q;
  assign resp_data_o = {data_q[1], data_q[0]};
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed + random checks of alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;
  logic        clk = 1'b0, reset_i = 1'b1;
  logic [1:0]  req_v_i = '0, resp_yumi_i = '0;
  logic [63:0] req_op_i = '0, req_rs1_i = '0, req_rs2_i = '0;
  logic [1:0]  req_ready_o, resp_v_o, resp_jump_o;
  logic [63:0] resp_data_o;
  logic [31:0] alu_op_o, alu_rs1_o, alu_rs2_o, alu_result_i;
  logic        alu_jump_i;

  localparam logic [31:0] ADD = 32'h00000033, SUB = 32'h40000033, XOR_ = 32'h00004033,
    OR_ = 32'h00006033, AND_ = 32'h00007033, BEQ = 32'h00000063, BNE = 32'h00001063;
  logic [31:0] ops [7] = '{ADD, SUB, XOR_, OR_, AND_, BEQ, BNE};

  alu_share_arbiter dut (
    .clk_i(clk), .reset_i(reset_i), .req_v_i(req_v_i), .req_op_i(req_op_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_ready_o(req_ready_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_jump_o(resp_jump_o),
    .resp_yumi_i(resp_yumi_i), .alu_op_o(alu_op_o), .alu_rs1_o(alu_rs1_o),
    .alu_rs2_o(alu_rs2_o), .alu_result_i(alu_result_i), .alu_jump_i(alu_jump_i));

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_f(logic [31:0] op, logic [31:0] a, logic [31:0] b);
    logic [2:0] f3;
    f3 = op[14:12];
    if (op[6:0] == 7'h63) return {f3 == 3'd0 ? a == b : f3 == 3'd1 ? a != b : 1'b0, a - b};
    case (f3)
      3'd0: return {1'b0, op[30] ? a - b : a + b};
      3'd4: return {1'b0, a ^ b};
      3'd6: return {1'b0, a | b};
      3'd7: return {1'b0, a & b};
      default: return 33'd0;
    endcase
  endfunction

  always_comb {alu_jump_i, alu_result_i} = alu_f(alu_op_o, alu_rs1_o, alu_rs2_o);

  // Model: one in-flight op (busy/owner/payload), two response slots, and the last grant.
  bit          m_busy;
  int          m_own, m_last;
  logic [31:0] m_op, m_a, m_b;
  bit   [1:0]  m_v;
  logic [31:0] m_data [2];
  bit          m_jmp [2];
  int          ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_last = 1; m_v = '0;
    m_op = '0; m_a = '0; m_b = '0;
    for (int r = 0; r < 2; r++) begin m_data[r] = '0; m_jmp[r] = 0; end
  endtask

  task automatic set_req(input int r, input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op_i[r*32 +: 32] = op;
    req_rs1_i[r*32 +: 32] = a;
    req_rs2_i[r*32 +: 32] = b;
  endtask

  // Inputs are set at posedge+2; outputs checked before the next edge, then the model steps.
  task automatic tick();
    bit [1:0] el;
    int g;
    bit acc;
    logic [32:0] x;
    for (int r = 0; r < 2; r++)
      el[r] = req_v_i[r] && (!m_v[r] || resp_yumi_i[r]) && !(m_busy && m_own == r);
    acc = |el;
`ifdef ALU_SHARE_ARBITER_FIXED_PRIO_EN
    g = el[0] ? 0 : 1;
`else
    g = el == 2'b11 ? (m_last == 0 ? 1 : 0) : (el[1] ? 1 : 0);
`endif
    #1;
    chk("ready", req_ready_o, acc ? (64'd1 << g) : 64'd0);
    chk("alu_op", alu_op_o, m_busy ? m_op : 32'd0);
    chk("alu_rs1", alu_rs1_o, m_busy ? m_a : 32'd0);
    chk("alu_rs2", alu_rs2_o, m_busy ? m_b : 32'd0);
    chk("resp_v", resp_v_o, m_v);
    for (int r = 0; r < 2; r++)
      if (m_v[r]) begin
        chk("resp_data", resp_data_o[r*32 +: 32], m_data[r]);
        chk("resp_jump", resp_jump_o[r], m_jmp[r]);
      end
    @(posedge clk);
    for (int r = 0; r < 2; r++) if (resp_yumi_i[r]) m_v[r] = 0;
    if (m_busy) begin
      x = alu_f(m_op, m_a, m_b);
      m_v[m_own] = 1; m_data[m_own] = x[31:0]; m_jmp[m_own] = x[32];
    end
    if (acc) begin
      m_busy = 1; m_own = g; m_last = g;
      m_op = req_op_i[g*32 +: 32]; m_a = req_rs1_i[g*32 +: 32]; m_b = req_rs2_i[g*32 +: 32];
    end else m_busy = 0;
    #2;
  endtask

  initial begin
    model_reset();
    req_v_i = 2'b11;
    #7;
    chk("rst_ready", req_ready_o, 2'b00);
    chk("rst_resp_v", resp_v_o, 2'b00);
    chk("rst_data", resp_data_o, 64'd0);
    chk("rst_alu_op", alu_op_o, 32'd0);
    req_v_i = 2'b00;
    reset_i = 1'b0;
    @(posedge clk); #2;
    // ADD on requester 0: result visible after the second edge
    set_req(0, ADD, 32'd5, 32'd7); req_v_i = 2'b01;
    tick();
    req_v_i = 2'b00;
    tick();
    #1;
    chk("add_v", resp_v_o[0], 1'b1);
    chk("add_data", resp_data_o[31:0], 32'd12);
    #1;
    resp_yumi_i = 2'b01; tick(); resp_yumi_i = 2'b00;
    // BEQ held unconsumed: requester 0 stalls until yumi
    set_req(0, BEQ, 32'd9, 32'd9); req_v_i = 2'b01;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("beq_stall", req_ready_o[0], k == 0 ? 1'b0 : 1'b0);
      if (k > 0) chk("beq_jump", resp_jump_o[0], 1'b1);
      tick();
    end
    resp_yumi_i = 2'b01;
    #1 chk("beq_release", req_ready_o[0], 1'b1);
    tick();
    req_v_i = 2'b00; resp_yumi_i = 2'b00;
    tick();
    resp_yumi_i = 2'b01; tick(); resp_yumi_i = 2'b00;
    // SUB on requester 1: blocked while its own op is in the issue register
    set_req(1, SUB, 32'd3, 32'd5); req_v_i = 2'b10;
    tick();
    #1 chk("sub_busy", req_ready_o[1], 1'b0);
    tick();
    req_v_i = 2'b00;
    #1;
    chk("sub_v", resp_v_o[1], 1'b1);
    chk("sub_data", resp_data_o[63:32], 32'hFFFFFFFE);
    #1;
    resp_yumi_i = 2'b10; tick(); resp_yumi_i = 2'b00;
    // both streaming, all responses consumed: strict alternation starting with 0
    req_v_i = 2'b11;
    for (int k = 0; k < 8; k++) begin
      set_req(0, ADD, 32'(k), 32'd100);
      set_req(1, XOR_, 32'(k), 32'hFF);
      resp_yumi_i = m_v;
      #1 chk("rr_alt", req_ready_o, k % 2 ? 2'b10 : 2'b01);
      tick();
    end
    req_v_i = 2'b00;
    for (int k = 0; k < 3; k++) begin resp_yumi_i = m_v; tick(); end
    resp_yumi_i = 2'b00;
    // reset while issuing with slot 1 full
    set_req(1, OR_, 32'hF0, 32'h0F); req_v_i = 2'b10; tick();
    req_v_i = 2'b00; tick();
    set_req(0, AND_, 32'hFF, 32'h3C); req_v_i = 2'b01; tick();
    req_v_i = 2'b11;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_v", resp_v_o, 2'b00);
    chk("mid_rst_alu", alu_op_o, 32'd0);
    chk("mid_rst_ready", req_ready_o, 2'b00);
    model_reset();
    @(posedge clk); #2;
    reset_i = 1'b0;
    #1 chk("tie_after_rst", req_ready_o, 2'b01);
    tick();
    tick();
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      req_v_i = 2'($urandom);
      for (int r = 0; r < 2; r++)
        set_req(r, ops[$urandom_range(0, 6)],
                $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom,
                $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom);
      resp_yumi_i = m_v & 2'($urandom);
      tick();
    end
    req_v_i = 2'b00;
    for (int k = 0; k < 3; k++) begin resp_yumi_i = m_v; tick(); end
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule
